// File: rtl/bw_game_pkg.sv
// Shared state codes, result encodings and defaults for the
// Black-and-White card game controller.
package bw_game_pkg;

    localparam int NUM_CARDS_DEF  = 9;
    localparam int WIN_TARGET_DEF = 5;

    typedef enum logic [2:0] {
        ST_INIT  = 3'b000,
        ST_RASP  = 3'b001,
        ST_BAWP  = 3'b010,
        ST_P1    = 3'b011,
        ST_P2    = 3'b100,
        ST_MATCH = 3'b101,
        ST_GAME  = 3'b110,
        ST_BAD   = 3'b111
    } state_t;

    typedef enum logic [1:0] {
        RES_NONE = 2'b00,
        RES_P1   = 2'b01,
        RES_P2   = 2'b10,
        RES_DRAW = 2'b11
    } result_t;

    // Larger first operand means player 1 takes it.
    function automatic result_t cmp_result(
        input logic [3:0] a,
        input logic [3:0] b
    );
        if (a > b)
            return RES_P1;
        else if (a < b)
            return RES_P2;
        else
            return RES_DRAW;
    endfunction

endpackage

// File: rtl/bw_game_ctrl_if.sv
// Button/switch inputs and print-path outputs of the game
// controller, bundled for the front end and the print mux.
interface bw_game_if;

    logic       next_btn;
    logic       card_valid;
    logic [3:0] card_in;
    logic [2:0] state;
    logic [3:0] round;
    logic [3:0] win;
    logic [3:0] lose;
    logic [3:0] p1_black;
    logic [3:0] p1_white;
    logic [3:0] p2_black;
    logic [3:0] p2_white;
    logic [1:0] matchresult;
    logic [1:0] gameresult;
    logic       card_err;

    modport master (
        output next_btn,
        output card_valid,
        output card_in,
        input  state,
        input  round,
        input  win,
        input  lose,
        input  p1_black,
        input  p1_white,
        input  p2_black,
        input  p2_white,
        input  matchresult,
        input  gameresult,
        input  card_err
    );

    modport slave (
        input  next_btn,
        input  card_valid,
        input  card_in,
        output state,
        output round,
        output win,
        output lose,
        output p1_black,
        output p1_white,
        output p2_black,
        output p2_white,
        output matchresult,
        output gameresult,
        output card_err
    );

endinterface

// File: rtl/bw_card_bank.sv
// One player's hand: used-card mask plus remaining black (even)
// and white (odd) card counts.
module bw_card_bank
    import bw_game_pkg::*;
#(
    parameter int NUM_CARDS = NUM_CARDS_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_clear,
    input  logic       i_consume,
    input  logic [3:0] i_card,
    output logic       o_legal,
    output logic [3:0] o_black,
    output logic [3:0] o_white
);

    localparam logic [3:0] BLACK_INIT = 4'((NUM_CARDS + 1) / 2);
    localparam logic [3:0] WHITE_INIT = 4'(NUM_CARDS / 2);

    logic [15:0] r_used;
    logic [3:0]  r_black;
    logic [3:0]  r_white;
    logic        w_in_range;
    logic        w_take;

    assign w_in_range = {28'd0, i_card} < 32'(NUM_CARDS);
    assign o_legal    = w_in_range && !r_used[i_card];
    // Only a legal card is consumed, so the counts cannot underflow.
    assign w_take     = i_consume && o_legal;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_used  <= '0;
            r_black <= BLACK_INIT;
            r_white <= WHITE_INIT;
        end else if (i_clear) begin
            r_used  <= '0;
            r_black <= BLACK_INIT;
            r_white <= WHITE_INIT;
        end else if (w_take) begin
            r_used[i_card] <= 1'b1;
            if (i_card[0])
                r_white <= r_white - 4'd1;
            else
                r_black <= r_black - 4'd1;
        end
    end

    assign o_black = r_black;
    assign o_white = r_white;

endmodule

// File: rtl/bw_game_ctrl.sv
// Sequencing FSM for the Black-and-White game: turns, match
// decisions, score counters and the final game verdict.
module bw_game_ctrl
    import bw_game_pkg::*;
#(
    parameter int NUM_CARDS  = NUM_CARDS_DEF,
    parameter int WIN_TARGET = WIN_TARGET_DEF
) (
    input  logic   clk,
    input  logic   reset_n,
    bw_game_if.slave bus
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_CARDS);
    localparam logic [3:0] WIN_LIMIT  = 4'(WIN_TARGET);

    state_t     r_state;
    logic [3:0] r_round;
    logic [3:0] r_win;
    logic [3:0] r_lose;
    logic [3:0] r_p1_card;
    result_t    r_mres;
    result_t    r_gres;
    logic       r_err;

    state_t     w_state_nxt;
    logic [3:0] w_round_nxt;
    logic [3:0] w_win_nxt;
    logic [3:0] w_lose_nxt;
    logic [3:0] w_p1_card_nxt;
    result_t    w_mres_nxt;
    result_t    w_gres_nxt;
    result_t    w_cmp;
    logic       w_err_nxt;
    logic       w_clear;
    logic       w_p1_take;
    logic       w_p2_take;
    logic       w_p1_legal;
    logic       w_p2_legal;
    logic       w_game_over;

    assign w_cmp       = cmp_result(r_p1_card, bus.card_in);
    assign w_game_over = (r_win == WIN_LIMIT) ||
                         (r_lose == WIN_LIMIT) ||
                         (r_round == LAST_ROUND);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_INIT;
            r_round   <= 4'd0;
            r_win     <= 4'd0;
            r_lose    <= 4'd0;
            r_p1_card <= 4'd0;
            r_mres    <= RES_NONE;
            r_gres    <= RES_NONE;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_round   <= w_round_nxt;
            r_win     <= w_win_nxt;
            r_lose    <= w_lose_nxt;
            r_p1_card <= w_p1_card_nxt;
            r_mres    <= w_mres_nxt;
            r_gres    <= w_gres_nxt;
            r_err     <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_round_nxt   = r_round;
        w_win_nxt     = r_win;
        w_lose_nxt    = r_lose;
        w_p1_card_nxt = r_p1_card;
        w_mres_nxt    = r_mres;
        w_gres_nxt    = r_gres;
        w_err_nxt     = 1'b0;
        w_clear       = 1'b0;
        w_p1_take     = 1'b0;
        w_p2_take     = 1'b0;

        unique case (r_state)
            ST_INIT: begin
                if (bus.next_btn) begin
                    w_state_nxt = ST_RASP;
                    w_round_nxt = 4'd1;
                end
            end
            ST_RASP: begin
                if (bus.next_btn)
                    w_state_nxt = ST_BAWP;
            end
            ST_BAWP: begin
                if (bus.next_btn)
                    w_state_nxt = ST_P1;
            end
            ST_P1: begin
                if (bus.card_valid) begin
                    if (w_p1_legal) begin
                        w_p1_take     = 1'b1;
                        w_p1_card_nxt = bus.card_in;
                        w_state_nxt   = ST_P2;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            ST_P2: begin
                if (bus.card_valid) begin
                    if (w_p2_legal) begin
                        w_p2_take   = 1'b1;
                        w_mres_nxt  = w_cmp;
                        w_state_nxt = ST_MATCH;
                        if (w_cmp == RES_P1)
                            w_win_nxt = r_win + 4'd1;
                        else if (w_cmp == RES_P2)
                            w_lose_nxt = r_lose + 4'd1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            ST_MATCH: begin
                if (bus.next_btn) begin
                    if (w_game_over) begin
                        w_state_nxt = ST_GAME;
                        w_gres_nxt  = cmp_result(r_win, r_lose);
                    end else begin
                        w_state_nxt = ST_RASP;
                        w_round_nxt = r_round + 4'd1;
                        w_mres_nxt  = RES_NONE;
                    end
                end
            end
            ST_GAME: begin
                if (bus.next_btn)
                    w_clear = 1'b1;
            end
            default: begin
                // Unreachable code: recover straight into a fresh game.
                w_clear = 1'b1;
            end
        endcase

        if (w_clear) begin
            w_state_nxt   = ST_INIT;
            w_round_nxt   = 4'd0;
            w_win_nxt     = 4'd0;
            w_lose_nxt    = 4'd0;
            w_p1_card_nxt = 4'd0;
            w_mres_nxt    = RES_NONE;
            w_gres_nxt    = RES_NONE;
        end
    end

    bw_card_bank #(
        .NUM_CARDS (NUM_CARDS)
    ) u_p1_bank (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (w_clear),
        .i_consume (w_p1_take),
        .i_card    (bus.card_in),
        .o_legal   (w_p1_legal),
        .o_black   (bus.p1_black),
        .o_white   (bus.p1_white)
    );

    bw_card_bank #(
        .NUM_CARDS (NUM_CARDS)
    ) u_p2_bank (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (w_clear),
        .i_consume (w_p2_take),
        .i_card    (bus.card_in),
        .o_legal   (w_p2_legal),
        .o_black   (bus.p2_black),
        .o_white   (bus.p2_white)
    );

    assign bus.state       = r_state;
    assign bus.round       = r_round;
    assign bus.win         = r_win;
    assign bus.lose        = r_lose;
    assign bus.matchresult = r_mres;
    assign bus.gameresult  = r_gres;
    assign bus.card_err    = r_err;

endmodule

// File: tb/tb_bw_game_ctrl.sv
// Bench for bw_game_ctrl: directed game script plus random play,
// all checked against a rules-level model of the game.
module tb_bw_game_ctrl;

    localparam int NC = 9;
    localparam int WT = 5;

    logic clk;
    logic reset_n;

    bw_game_if bif();

    bw_game_ctrl #(
        .NUM_CARDS  (NC),
        .WIN_TARGET (WT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif)
    );

    int n_tests;
    int n_fail;

    // Rules-level model of the game.
    int m_st, m_round, m_win, m_lose, m_mres, m_gres, m_err, m_p1c;
    bit u1 [16];
    bit u2 [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        m_st = 0; m_round = 0; m_win = 0; m_lose = 0;
        m_mres = 0; m_gres = 0; m_err = 0; m_p1c = 0;
        for (int i = 0; i < 16; i++) begin
            u1[i] = 1'b0;
            u2[i] = 1'b0;
        end
    endfunction

    function automatic int left(input bit p2, input int parity);
        int n;
        n = 0;
        for (int c = 0; c < NC; c++)
            if ((c % 2) == parity && !(p2 ? u2[c] : u1[c]))
                n++;
        return n;
    endfunction

    function automatic void model_step(input bit nb, input bit cv,
                                       input int c);
        m_err = 0;
        case (m_st)
            0: if (nb) begin m_st = 1; m_round = 1; end
            1: if (nb) m_st = 2;
            2: if (nb) m_st = 3;
            3: if (cv) begin
                if (c < NC && !u1[c]) begin
                    u1[c] = 1'b1; m_p1c = c; m_st = 4;
                end else m_err = 1;
            end
            4: if (cv) begin
                if (c < NC && !u2[c]) begin
                    u2[c] = 1'b1; m_st = 5;
                    if (m_p1c > c) begin m_win++; m_mres = 1; end
                    else if (m_p1c < c) begin m_lose++; m_mres = 2; end
                    else m_mres = 3;
                end else m_err = 1;
            end
            5: if (nb) begin
                if (m_win == WT || m_lose == WT || m_round == NC) begin
                    m_st = 6;
                    m_gres = (m_win > m_lose) ? 1 :
                             (m_lose > m_win) ? 2 : 3;
                end else begin
                    m_st = 1; m_round++; m_mres = 0;
                end
            end
            6: if (nb) model_reset();
            default: model_reset();
        endcase
    endfunction

    initial model_reset();

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            model_reset();
        else
            model_step(bif.next_btn, bif.card_valid, int'(bif.card_in));
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        chk("state", 32'(bif.state), 32'(m_st));
        chk("round", 32'(bif.round), 32'(m_round));
        chk("win", 32'(bif.win), 32'(m_win));
        chk("lose", 32'(bif.lose), 32'(m_lose));
        chk("p1_black", 32'(bif.p1_black), 32'(left(1'b0, 0)));
        chk("p1_white", 32'(bif.p1_white), 32'(left(1'b0, 1)));
        chk("p2_black", 32'(bif.p2_black), 32'(left(1'b1, 0)));
        chk("p2_white", 32'(bif.p2_white), 32'(left(1'b1, 1)));
        chk("matchresult", 32'(bif.matchresult), 32'(m_mres));
        chk("gameresult", 32'(bif.gameresult), 32'(m_gres));
        chk("card_err", 32'(bif.card_err), 32'(m_err));
    end

    task automatic cyc(input bit nb, input bit cv, input int c);
        @(negedge clk);
        bif.next_btn   = nb;
        bif.card_valid = cv;
        bif.card_in    = 4'(c);
        @(posedge clk);
        #2;
        bif.next_btn   = 1'b0;
        bif.card_valid = 1'b0;
    endtask

    task automatic chk_init_outputs(input string tag);
        chk({tag, "_state"}, 32'(bif.state), 32'd0);
        chk({tag, "_round"}, 32'(bif.round), 32'd0);
        chk({tag, "_win"}, 32'(bif.win), 32'd0);
        chk({tag, "_lose"}, 32'(bif.lose), 32'd0);
        chk({tag, "_p1b"}, 32'(bif.p1_black), 32'd5);
        chk({tag, "_p1w"}, 32'(bif.p1_white), 32'd4);
        chk({tag, "_p2b"}, 32'(bif.p2_black), 32'd5);
        chk({tag, "_p2w"}, 32'(bif.p2_white), 32'd4);
        chk({tag, "_mres"}, 32'(bif.matchresult), 32'd0);
        chk({tag, "_gres"}, 32'(bif.gameresult), 32'd0);
        chk({tag, "_err"}, 32'(bif.card_err), 32'd0);
    endtask

    int p1s [5] = '{0, 1, 2, 4, 5};
    int p2s [5] = '{1, 2, 5, 6, 8};

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        bif.next_btn   = 1'b0;
        bif.card_valid = 1'b0;
        bif.card_in    = 4'd0;
        #22 reset_n = 1'b1;
        #1 chk_init_outputs("reset");

        repeat (3) cyc(1'b1, 1'b0, 0);
        chk("p1turn_state", 32'(bif.state), 32'd3);
        chk("p1turn_round", 32'(bif.round), 32'd1);

        cyc(1'b0, 1'b1, 9);
        chk("bad9_err", 32'(bif.card_err), 32'd1);
        chk("bad9_state", 32'(bif.state), 32'd3);
        cyc(1'b0, 1'b0, 0);
        chk("bad9_err_clr", 32'(bif.card_err), 32'd0);

        cyc(1'b0, 1'b1, 7);
        cyc(1'b0, 1'b1, 4);
        chk("m1_state", 32'(bif.state), 32'd5);
        chk("m1_mres", 32'(bif.matchresult), 32'd1);
        chk("m1_win", 32'(bif.win), 32'd1);
        chk("m1_p1w", 32'(bif.p1_white), 32'd3);
        chk("m1_p2b", 32'(bif.p2_black), 32'd4);

        cyc(1'b1, 1'b0, 0);
        chk("r2_round", 32'(bif.round), 32'd2);
        chk("r2_mres", 32'(bif.matchresult), 32'd0);
        cyc(1'b1, 1'b0, 0);
        cyc(1'b1, 1'b0, 0);
        cyc(1'b0, 1'b1, 7);
        chk("replay_err", 32'(bif.card_err), 32'd1);
        chk("replay_p1w", 32'(bif.p1_white), 32'd3);
        chk("replay_state", 32'(bif.state), 32'd3);

        cyc(1'b0, 1'b1, 3);
        cyc(1'b0, 1'b1, 3);
        chk("draw_mres", 32'(bif.matchresult), 32'd3);
        chk("draw_win", 32'(bif.win), 32'd1);
        chk("draw_lose", 32'(bif.lose), 32'd0);
        cyc(1'b1, 1'b1, 2);
        chk("r3_state", 32'(bif.state), 32'd1);
        chk("r3_round", 32'(bif.round), 32'd3);
        chk("r3_mres", 32'(bif.matchresult), 32'd0);

        cyc(1'b0, 1'b1, 5);
        chk("rasp_cv_state", 32'(bif.state), 32'd1);
        chk("rasp_cv_err", 32'(bif.card_err), 32'd0);

        cyc(1'b1, 1'b0, 0);
        cyc(1'b1, 1'b0, 0);
        for (int r = 0; r < 5; r++) begin
            cyc(1'b0, 1'b1, p1s[r]);
            cyc(1'b1, 1'b1, p2s[r]);
            chk("p2run_mres", 32'(bif.matchresult), 32'd2);
            if (r < 4) repeat (3) cyc(1'b1, 1'b0, 0);
        end
        chk("p2run_lose", 32'(bif.lose), 32'd5);
        cyc(1'b1, 1'b0, 0);
        chk("game_state", 32'(bif.state), 32'd6);
        chk("game_gres", 32'(bif.gameresult), 32'd2);
        chk("game_mres", 32'(bif.matchresult), 32'd2);
        cyc(1'b1, 1'b0, 0);
        chk_init_outputs("restart");

        repeat (3) cyc(1'b1, 1'b0, 0);
        cyc(1'b0, 1'b1, 2);
        chk("pre_rst_p1b", 32'(bif.p1_black), 32'd4);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk_init_outputs("async");
        #1 reset_n = 1'b1;

        for (int i = 0; i < 4000; i++) begin
            int r;
            int c;
            r = int'($urandom_range(0, 3));
            c = ($urandom_range(0, 7) == 0) ?
                int'($urandom_range(0, 15)) : int'($urandom_range(0, 8));
            cyc(r == 0 || r == 2, r == 1 || r == 2, c);
            if ($urandom_range(0, 399) == 0) begin
                reset_n = 1'b0;
                #4 reset_n = 1'b1;
            end
        end

        repeat (2) @(posedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bw_game_ctrl.md
Name: bw_game_ctrl

Overview:
- Sequencing FSM for the Black-and-White card game.
- Drives the display-select state code and every score/colour counter consumed by the print-select mux.
- Validates and records each player's card, decides each match, and decides the overall game.
- Sits between the debounced button/switch front end and the 16-bit print path.

Parameters:
NUM_CARDS, 9, cards per player, valued 0..NUM_CARDS-1 (max 15); also the maximum round count.
WIN_TARGET, 5, match wins that end the game early (NUM_CARDS/2+1).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
next_btn  in  1  one-cycle pulse, advances display states
card_valid  in  1  one-cycle pulse, submits card_in for the player whose turn it is
card_in  in  4  card value from switches
state  out  3  print-select code: 000 init, 001 rasp, 010 bawp, 011 p1_turn, 100 p2_turn, 101 matchresult_print, 110 gameresult_print
round  out  4  current round, 1-based (0 in init)
win  out  4  P1 match wins
lose  out  4  P1 match losses (= P2 wins)
p1_black  out  4  P1 unplayed even cards
p1_white  out  4  P1 unplayed odd cards
p2_black  out  4  P2 unplayed even cards
p2_white  out  4  P2 unplayed odd cards
matchresult  out  2  00 none, 01 P1 wins, 10 P2 wins, 11 draw
gameresult  out  2  00 none, 01 P1 wins, 10 P2 wins, 11 draw
card_err  out  1  one-cycle pulse on a rejected card

Behaviour:
- All outputs and state are registered.
- Reset (asynchronous, any time, including mid-turn) forces:
  - state=000, round=0, win=lose=0
  - p1_black=p2_black=(NUM_CARDS+1)/2, p1_white=p2_white=NUM_CARDS/2 (5/4 at default)
  - matchresult=gameresult=00, card_err=0
  - used masks cleared, held P1 card cleared
- Colour rule: even card = black, odd card = white.
- Transitions (one-cycle latency from pulse to new state):
  - INIT --next_btn--> RASP; round<=1.
  - RASP --next_btn--> BAWP.
  - BAWP --next_btn--> P1_TURN.
  - P1_TURN --card_valid with legal card--> P2_TURN.
    - Latch card_in into p1_card and set the P1 used bit.
    - Decrement p1_black or p1_white.
  - P2_TURN --card_valid with legal card--> MATCHRESULT.
    - Set the P2 used bit and decrement the matching P2 colour count.
    - Compare p1_card against card_in: greater gives matchresult=01 and win+1; less gives 10 and lose+1; equal gives 11.
  - MATCHRESULT --next_btn--> one of:
    - GAMERESULT if win==WIN_TARGET, lose==WIN_TARGET, or round==NUM_CARDS.
      - gameresult = 01 if win>lose, 10 if lose>win, 11 if equal.
    - Otherwise RASP, with round+1 and matchresult<=00.
  - GAMERESULT --next_btn--> INIT, with full re-initialisation equal to reset.
- Legal card: card_in<NUM_CARDS and that player's used bit is clear.
  - Illegal submission: card_err=1 for exactly one cycle; state, counters and masks unchanged.
- Ignored inputs:
  - card_valid outside P1_TURN/P2_TURN is ignored, with no card_err.
  - next_btn inside P1_TURN/P2_TURN is ignored.
  - If next_btn and card_valid arrive in the same cycle, only the input relevant to the current state acts.
- matchresult holds its value through MATCHRESULT and GAMERESULT; it clears on entering RASP or INIT.
- gameresult is non-zero only in GAMERESULT.
- Counters never wrap: round ≤ NUM_CARDS, and win+lose ≤ round.
- State codes 111 are unreachable; if ever entered, go to INIT on the next clock.

Decomposition:
- Shared package bw_game_pkg holds:
  - state code constants (INIT..GAMERESULT)
  - matchresult/gameresult encodings
  - NUM_CARDS default
- Natural sub-module bw_card_bank, instantiated twice (P1, P2):
  - holds the used mask and black/white counts
  - provides a legal-check output and a consume input
  - has a clear input driven at INIT re-entry
- FSM, comparator and score counters stay in bw_game_ctrl.

Test Plan:
- Reset then 3× next_btn -> state 000→001→010→011; round=1; all four colour counts = 5/4/5/4.
- In P1_TURN, card_in=7 valid; then in P2_TURN card_in=4 valid -> state=101, matchresult=01, win=1, p1_white=3, p2_black=4.
- In P1_TURN, card_in=9 -> card_err one cycle, state stays 011. Next round, P1 replays card 7 -> card_err, counts unchanged.
- Equal cards 3 vs 3 -> matchresult=11, win/lose unchanged. next_btn -> state=001, round+1, matchresult=00.
- P2 wins 5 straight rounds -> after 5th MATCHRESULT, next_btn gives state=110, gameresult=10, lose=5. Next next_btn -> INIT with all counters reset.
- Assert reset_n low asynchronously mid-P2_TURN -> outputs immediately at reset values. card_valid pulsed while in RASP -> no state change, no card_err.
